// File: rtl/vga_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// vga_pkg : RGB565 colours, pattern-select codes and FSM state type
// Rev 1.0
// ------------------------------------------------------------------
package vga_pkg;

  localparam int LINE_WORDS = 1024;

  localparam logic [15:0] WHITE   = 16'hFFFF;
  localparam logic [15:0] YELLOW  = 16'hFFE0;
  localparam logic [15:0] CYAN    = 16'h07FF;
  localparam logic [15:0] GREEN   = 16'h07E0;
  localparam logic [15:0] MAGENTA = 16'hF81F;
  localparam logic [15:0] RED     = 16'hF800;
  localparam logic [15:0] BLUE    = 16'h001F;
  localparam logic [15:0] BLACK   = 16'h0000;

  localparam logic [1:0] PAT_SOLID   = 2'd0;
  localparam logic [1:0] PAT_BARS    = 2'd1;
  localparam logic [1:0] PAT_CHECKER = 2'd2;
  localparam logic [1:0] PAT_ADDR    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GRANT_WAIT = 3'd1,
    ST_LAT_WAIT   = 3'd2,
    ST_DATA       = 3'd3,
    ST_RECOVER    = 3'd4
  } state_t;

  // Eight 128-pixel colour bars, left to right
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = WHITE;
      3'd1:    bar_color = YELLOW;
      3'd2:    bar_color = CYAN;
      3'd3:    bar_color = GREEN;
      3'd4:    bar_color = MAGENTA;
      3'd5:    bar_color = RED;
      3'd6:    bar_color = BLUE;
      default: bar_color = BLACK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_line_fill_responder_if.sv
`default_nettype none
// ------------------------------------------------------------------
// vga_line_fill_responder_if : line-fill burst handshake bundle
// Rev 1.0
// ------------------------------------------------------------------
interface vga_line_fill_responder_if;
  logic        line_req;
  logic        line_grant;
  logic [23:0] line_addr;
  logic [15:0] line_data;
  logic        line_valid;
  logic        line_done;

  modport master (
    output line_req, line_addr,
    input  line_grant, line_data, line_valid, line_done
  );

  modport slave (
    input  line_req, line_addr,
    output line_grant, line_data, line_valid, line_done
  );
endinterface
`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// vga_pattern_gen : combinational synthetic RGB565 word from address
// Rev 1.0
// ------------------------------------------------------------------
module vga_pattern_gen
  import vga_pkg::*;
(
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_color,
  input  logic [15:0] addr,
  output logic [15:0] rgb
);

  // x is the low LINE_WORDS-wide field of the address, y the field above it
  localparam int c_X_W = $clog2(LINE_WORDS);

  always_comb begin
    rgb = addr;
    case (pattern_sel)
      PAT_SOLID:   rgb = solid_color;
      PAT_BARS:    rgb = bar_color(addr[c_X_W-1 -: 3]);
      PAT_CHECKER: rgb = (addr[5] ^ addr[c_X_W+5]) ? WHITE : BLACK;
      default:     rgb = addr;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/vga_line_fill_responder.sv
`default_nettype none
// ------------------------------------------------------------------
// vga_line_fill_responder : synthetic burst responder for the VGA line-fill FSM
// Rev 1.0
// ------------------------------------------------------------------
module vga_line_fill_responder
  import vga_pkg::*;
#(
  parameter int BURST_LEN   = 256,
  parameter int GRANT_LAT   = 2,
  parameter int DATA_LAT    = 3,
  parameter int STALL_EVERY = 0
) (
  input  logic                        clk_vga,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [1:0]                  pattern_sel,
  input  logic [15:0]                 solid_color,
  vga_line_fill_responder_if.slave    bus,
  output logic                        busy,
  output logic [15:0]                 burst_count,
  output logic                        abort_seen
);

  localparam int c_LAT_W = 16;
  localparam int c_WC_W  = $clog2(BURST_LEN + 1);
  localparam int c_SC_W  = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;

  state_t              r_state;
  logic [c_LAT_W-1:0]  r_lat_cnt;
  logic [23:0]         r_cur_addr;
  logic [c_WC_W-1:0]   r_word_cnt;
  logic [c_SC_W-1:0]   r_stall_cnt;
  logic                r_stall_pend;
  logic                r_grant;
  logic                r_valid;
  logic                r_done;
  logic [15:0]         r_data;
  logic                r_busy;
  logic [15:0]         r_burst_count;
  logic                r_abort;
  logic [15:0]         w_pix;

  vga_pattern_gen u_pattern_gen (
    .pattern_sel (pattern_sel),
    .solid_color (solid_color),
    .addr        (r_cur_addr[15:0]),
    .rgb         (w_pix)
  );

  // Latency counters are preloaded one short so that the registered grant and
  // first valid land exactly GRANT_LAT / DATA_LAT cycles after their trigger.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_lat_cnt     <= '0;
      r_cur_addr    <= '0;
      r_word_cnt    <= '0;
      r_stall_cnt   <= '0;
      r_stall_pend  <= 1'b0;
      r_grant       <= 1'b0;
      r_valid       <= 1'b0;
      r_done        <= 1'b0;
      r_data        <= '0;
      r_busy        <= 1'b0;
      r_burst_count <= '0;
      r_abort       <= 1'b0;
    end else begin
      r_grant <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.line_req && enable) begin
            r_cur_addr   <= bus.line_addr;
            r_word_cnt   <= '0;
            r_stall_cnt  <= '0;
            r_stall_pend <= 1'b0;
            r_busy       <= 1'b1;
            if (GRANT_LAT == 0) begin
              r_grant <= 1'b1;
              if (DATA_LAT == 1) begin
                r_state <= ST_DATA;
              end else begin
                r_lat_cnt <= c_LAT_W'(DATA_LAT - 2);
                r_state   <= ST_LAT_WAIT;
              end
            end else begin
              r_lat_cnt <= c_LAT_W'(GRANT_LAT - 1);
              r_state   <= ST_GRANT_WAIT;
            end
          end
        end

        ST_GRANT_WAIT: begin
          if (!bus.line_req) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_abort <= 1'b1;
          end else if (r_lat_cnt == '0) begin
            r_grant <= 1'b1;
            if (DATA_LAT == 1) begin
              r_state <= ST_DATA;
            end else begin
              r_lat_cnt <= c_LAT_W'(DATA_LAT - 2);
              r_state   <= ST_LAT_WAIT;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt - c_LAT_W'(1);
          end
        end

        ST_LAT_WAIT: begin
          if (!bus.line_req) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_abort <= 1'b1;
          end else if (r_lat_cnt == '0) begin
            r_state <= ST_DATA;
          end else begin
            r_lat_cnt <= r_lat_cnt - c_LAT_W'(1);
          end
        end

        ST_DATA: begin
          if (!bus.line_req) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_abort <= 1'b1;
          end else if (r_stall_pend) begin
            r_stall_pend <= 1'b0;
          end else begin
            r_valid    <= 1'b1;
            r_data     <= w_pix;
            r_cur_addr <= r_cur_addr + 24'd1;
            if (r_word_cnt == c_WC_W'(BURST_LEN - 1)) begin
              r_done        <= 1'b1;
              r_word_cnt    <= '0;
              r_burst_count <= r_burst_count + 16'd1;
              r_state       <= ST_RECOVER;
            end else begin
              r_word_cnt <= r_word_cnt + c_WC_W'(1);
              if (STALL_EVERY > 0) begin
                if (r_stall_cnt == c_SC_W'(STALL_EVERY - 1)) begin
                  r_stall_cnt  <= '0;
                  r_stall_pend <= 1'b1;
                end else begin
                  r_stall_cnt <= r_stall_cnt + c_SC_W'(1);
                end
              end
            end
          end
        end

        ST_RECOVER: begin
          // A request still held after done belongs to the finished burst
          if (!bus.line_req) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.line_grant = r_grant;
  assign bus.line_valid = r_valid;
  assign bus.line_done  = r_done;
  assign bus.line_data  = r_data;
  assign busy           = r_busy;
  assign burst_count    = r_burst_count;
  assign abort_seen     = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_vga_line_fill_responder.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_vga_line_fill_responder : scoreboard bench for three responder configurations
// Rev 1.0
// ------------------------------------------------------------------
module tb_vga_line_fill_responder;

  logic        clk_vga = 1'b0;
  logic        rst_n   = 1'b1;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [15:0] solid_color;

  logic [2:0]  req_d;
  logic [23:0] addr_d [3];
  logic [2:0]  grant_m, valid_m, done_m, busy_m, abort_m;
  logic [15:0] data_m [3];
  logic [15:0] bc_m   [3];

  int errors = 0;
  int checks = 0;
  int burst_len [3] = '{256, 1024, 8};

  always #5 clk_vga = ~clk_vga;

  vga_line_fill_responder_if u_if0 ();
  vga_line_fill_responder_if u_if1 ();
  vga_line_fill_responder_if u_if2 ();

  assign u_if0.line_req  = req_d[0];
  assign u_if0.line_addr = addr_d[0];
  assign u_if1.line_req  = req_d[1];
  assign u_if1.line_addr = addr_d[1];
  assign u_if2.line_req  = req_d[2];
  assign u_if2.line_addr = addr_d[2];

  assign grant_m = {u_if2.line_grant, u_if1.line_grant, u_if0.line_grant};
  assign valid_m = {u_if2.line_valid, u_if1.line_valid, u_if0.line_valid};
  assign done_m  = {u_if2.line_done,  u_if1.line_done,  u_if0.line_done};
  assign data_m[0] = u_if0.line_data;
  assign data_m[1] = u_if1.line_data;
  assign data_m[2] = u_if2.line_data;

  vga_line_fill_responder #(.BURST_LEN(256), .GRANT_LAT(2), .DATA_LAT(3), .STALL_EVERY(0)) u_dut0 (
    .clk_vga(clk_vga), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .solid_color(solid_color), .bus(u_if0), .busy(busy_m[0]), .burst_count(bc_m[0]),
    .abort_seen(abort_m[0])
  );

  vga_line_fill_responder #(.BURST_LEN(1024), .GRANT_LAT(2), .DATA_LAT(3), .STALL_EVERY(0)) u_dut1 (
    .clk_vga(clk_vga), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .solid_color(solid_color), .bus(u_if1), .busy(busy_m[1]), .burst_count(bc_m[1]),
    .abort_seen(abort_m[1])
  );

  vga_line_fill_responder #(.BURST_LEN(8), .GRANT_LAT(2), .DATA_LAT(3), .STALL_EVERY(4)) u_dut2 (
    .clk_vga(clk_vga), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .solid_color(solid_color), .bus(u_if2), .busy(busy_m[2]), .burst_count(bc_m[2]),
    .abort_seen(abort_m[2])
  );

  function automatic logic [15:0] exp_pix(input logic [1:0] sel, input logic [15:0] solid,
                                          input logic [23:0] a);
    logic [15:0] r;
    case (sel)
      2'd0: r = solid;
      2'd1: begin
        case (a[9:7])
          3'd0: r = 16'hFFFF;
          3'd1: r = 16'hFFE0;
          3'd2: r = 16'h07FF;
          3'd3: r = 16'h07E0;
          3'd4: r = 16'hF81F;
          3'd5: r = 16'hF800;
          3'd6: r = 16'h001F;
          default: r = 16'h0000;
        endcase
      end
      2'd2: r = (a[5] ^ a[15]) ? 16'hFFFF : 16'h0000;
      default: r = a[15:0];
    endcase
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req_d = '0;
    for (int k = 0; k < 3; k++) addr_d[k] = '0;
    repeat (2) @(negedge clk_vga);
    rst_n = 1'b1;
    @(negedge clk_vga);
  endtask

  // Indices count negedges after the request is driven; outputs are sampled there.
  task automatic serve(input int id, input logic [23:0] addr, input logic [1:0] sel,
                       output int grant_at, output int first_at, output int last_at,
                       output int nwords, output int ngrants, output logic [15:0] vpat);
    logic [15:0] expq[$];
    logic [15:0] e;
    bit got_done;
    int lim;
    for (int i = 0; i < burst_len[id]; i++) expq.push_back(exp_pix(sel, solid_color, addr + 24'(i)));
    pattern_sel = sel;
    addr_d[id]  = addr;
    req_d[id]   = 1'b1;
    grant_at = -1; first_at = -1; last_at = -1; nwords = 0; ngrants = 0; vpat = '0;
    got_done = 1'b0;
    lim = burst_len[id] * 2 + 64;
    for (int cyc = 1; cyc <= lim && !got_done; cyc++) begin
      @(negedge clk_vga);
      if (grant_m[id]) begin
        ngrants++;
        if (grant_at < 0) grant_at = cyc;
      end
      if (valid_m[id] && first_at < 0) first_at = cyc;
      if (first_at >= 0) vpat = {vpat[14:0], valid_m[id]};
      if (valid_m[id]) begin
        nwords++;
        last_at = cyc;
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL dut%0d extra_word: got %h, expected no more words", id, data_m[id]);
        end else begin
          e = expq.pop_front();
          if (data_m[id] !== e) begin
            errors++;
            $display("FAIL dut%0d data word %0d: got %h, expected %h", id, nwords - 1, data_m[id], e);
          end
        end
      end
      if (done_m[id]) begin
        got_done = 1'b1;
        req_d[id] = 1'b0;
        checks++;
        if (!valid_m[id] || expq.size() != 0) begin
          errors++;
          $display("FAIL dut%0d done_position: valid=%b remaining=%0d, expected valid=1 remaining=0",
                   id, valid_m[id], expq.size());
        end
      end
    end
    checks++;
    if (!got_done) begin
      errors++;
      req_d[id] = 1'b0;
      $display("FAIL dut%0d done_timeout: no done within %0d cycles", id, lim);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_d = '0;
    @(negedge clk_vga);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({grant_m[k], valid_m[k], done_m[k], busy_m[k], abort_m[k]} !== 5'b0 ||
          data_m[k] !== 16'h0 || bc_m[k] !== 16'h0) begin
        errors++;
        $display("FAIL dut%0d reset_outputs: g/v/d/b/a=%b%b%b%b%b data=%h bc=%h, expected all 0",
                 k, grant_m[k], valid_m[k], done_m[k], busy_m[k], abort_m[k], data_m[k], bc_m[k]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk_vga);
  endtask

  task automatic test_basic();
    int ga, fa, la, nw, ng;
    logic [15:0] vp;
    do_reset();
    serve(0, 24'h000400, 2'd3, ga, fa, la, nw, ng, vp);
    checks++;
    if (ga !== 3) begin errors++; $display("FAIL grant_latency: got index %0d, expected 3", ga); end
    checks++;
    if (fa - ga !== 3) begin errors++; $display("FAIL data_latency: got %0d, expected 3", fa - ga); end
    checks++;
    if (nw !== 256 || ng !== 1) begin
      errors++; $display("FAIL basic_counts: words=%0d grants=%0d, expected 256 and 1", nw, ng);
    end
    checks++;
    if (bc_m[0] !== 16'd1) begin errors++; $display("FAIL basic_burst_count: got %0d, expected 1", bc_m[0]); end
    @(negedge clk_vga);
    checks++;
    if (busy_m[0] !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b, expected 0", busy_m[0]); end
  endtask

  task automatic test_back_to_back();
    int ga, fa, la, nw, ng, tot_w, tot_g, gap_g;
    logic [15:0] vp;
    do_reset();
    tot_w = 0; tot_g = 0; gap_g = 0;
    for (int b = 0; b < 4; b++) begin
      serve(0, 24'h000400 + 24'(256 * b), 2'd3, ga, fa, la, nw, ng, vp);
      tot_w += nw;
      tot_g += ng;
      repeat (2) begin
        @(negedge clk_vga);
        if (grant_m[0] || valid_m[0]) gap_g++;
      end
    end
    checks++;
    if (tot_g !== 4 || tot_w !== 1024 || gap_g !== 0) begin
      errors++;
      $display("FAIL b2b_counts: grants=%0d words=%0d gap_events=%0d, expected 4 1024 0", tot_g, tot_w, gap_g);
    end
    checks++;
    if (bc_m[0] !== 16'd4) begin errors++; $display("FAIL b2b_burst_count: got %0d, expected 4", bc_m[0]); end
  endtask

  task automatic test_stale();
    int ga, fa, la, nw, ng, ev;
    logic [15:0] vp;
    do_reset();
    serve(0, 24'h000800, 2'd3, ga, fa, la, nw, ng, vp);
    req_d[0] = 1'b1;
    ev = 0;
    repeat (6) begin
      @(negedge clk_vga);
      if (grant_m[0] || valid_m[0]) ev++;
    end
    checks++;
    if (ev !== 0 || busy_m[0] !== 1'b1) begin
      errors++; $display("FAIL stale_req: events=%0d busy=%b, expected 0 and 1", ev, busy_m[0]);
    end
    req_d[0] = 1'b0;
    repeat (2) @(negedge clk_vga);
    checks++;
    if (busy_m[0] !== 1'b0 || bc_m[0] !== 16'd1) begin
      errors++; $display("FAIL stale_release: busy=%b bc=%0d, expected 0 and 1", busy_m[0], bc_m[0]);
    end
  endtask

  task automatic test_bars();
    int ga, fa, la, nw, ng;
    logic [15:0] vp;
    do_reset();
    serve(1, 24'h000000, 2'd1, ga, fa, la, nw, ng, vp);
    checks++;
    if (nw !== 1024 || bc_m[1] !== 16'd1) begin
      errors++; $display("FAIL bars_counts: words=%0d bc=%0d, expected 1024 and 1", nw, bc_m[1]);
    end
    @(negedge clk_vga);
  endtask

  task automatic test_stall();
    int ga, fa, la, nw, ng;
    logic [15:0] vp;
    do_reset();
    serve(2, 24'h000010, 2'd3, ga, fa, la, nw, ng, vp);
    checks++;
    if (vp !== 16'b0000_0001_1110_1111 || la - fa + 1 !== 9 || nw !== 8) begin
      errors++;
      $display("FAIL stall_pattern: valid=%b span=%0d words=%0d, expected 111101111 9 8", vp, la - fa + 1, nw);
    end
    @(negedge clk_vga);
  endtask

  task automatic test_abort();
    int ga, fa, la, nw, ng, n;
    logic [15:0] vp;
    do_reset();
    addr_d[0] = 24'h001000;
    req_d[0]  = 1'b1;
    n = 0;
    for (int c = 0; c < 100 && n < 10; c++) begin
      @(negedge clk_vga);
      if (valid_m[0]) n++;
    end
    req_d[0] = 1'b0;
    checks++;
    if (n !== 10) begin errors++; $display("FAIL abort_setup: got %0d words, expected 10", n); end
    @(negedge clk_vga);
    checks++;
    if (valid_m[0] !== 1'b0 || done_m[0] !== 1'b0) begin
      errors++; $display("FAIL abort_valid: valid=%b done=%b, expected 0 0", valid_m[0], done_m[0]);
    end
    checks++;
    if (abort_m[0] !== 1'b1 || bc_m[0] !== 16'd0 || busy_m[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_flags: abort=%b bc=%0d busy=%b, expected 1 0 0", abort_m[0], bc_m[0], busy_m[0]);
    end
    serve(0, 24'h002000, 2'd3, ga, fa, la, nw, ng, vp);
    checks++;
    if (nw !== 256 || bc_m[0] !== 16'd1 || abort_m[0] !== 1'b1) begin
      errors++;
      $display("FAIL abort_recovery: words=%0d bc=%0d abort=%b, expected 256 1 1", nw, bc_m[0], abort_m[0]);
    end
    @(negedge clk_vga);
  endtask

  task automatic test_enable();
    int ga, fa, la, nw, ng, ev;
    logic [15:0] vp;
    do_reset();
    enable    = 1'b0;
    addr_d[0] = 24'h000400;
    req_d[0]  = 1'b1;
    ev = 0;
    repeat (6) begin
      @(negedge clk_vga);
      if (grant_m[0] || busy_m[0]) ev++;
    end
    checks++;
    if (ev !== 0) begin errors++; $display("FAIL enable_block: got %0d events, expected 0", ev); end
    enable = 1'b1;
    fork
      serve(0, 24'h000400, 2'd3, ga, fa, la, nw, ng, vp);
      begin
        repeat (8) @(negedge clk_vga);
        enable = 1'b0;
      end
    join
    checks++;
    if (nw !== 256 || bc_m[0] !== 16'd1) begin
      errors++; $display("FAIL enable_no_stop: words=%0d bc=%0d, expected 256 1", nw, bc_m[0]);
    end
    enable = 1'b1;
    @(negedge clk_vga);
  endtask

  task automatic test_patterns();
    int ga, fa, la, nw, ng;
    logic [15:0] vp;
    do_reset();
    solid_color = 16'hA5C3;
    serve(0, 24'h000123, 2'd0, ga, fa, la, nw, ng, vp);
    @(negedge clk_vga);
    serve(0, 24'h008000, 2'd2, ga, fa, la, nw, ng, vp);
    @(negedge clk_vga);
    serve(0, 24'h0003C0, 2'd2, ga, fa, la, nw, ng, vp);
    @(negedge clk_vga);
    checks++;
    if (bc_m[0] !== 16'd3) begin errors++; $display("FAIL pattern_bursts: got %0d, expected 3", bc_m[0]); end
  endtask

  task automatic test_reset_mid();
    int ga, fa, la, nw, ng, n, ev;
    logic [15:0] vp;
    do_reset();
    serve(0, 24'h000400, 2'd3, ga, fa, la, nw, ng, vp);
    @(negedge clk_vga);
    addr_d[0] = 24'h003000;
    req_d[0]  = 1'b1;
    n = 0;
    for (int c = 0; c < 50 && n < 5; c++) begin
      @(negedge clk_vga);
      if (valid_m[0]) n++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({grant_m[0], valid_m[0], done_m[0], busy_m[0], abort_m[0]} !== 5'b0 ||
        data_m[0] !== 16'h0 || bc_m[0] !== 16'h0 || n !== 5) begin
      errors++;
      $display("FAIL async_reset: g/v/d/b/a=%b%b%b%b%b data=%h bc=%0d words=%0d, expected 0s and 5 words",
               grant_m[0], valid_m[0], done_m[0], busy_m[0], abort_m[0], data_m[0], bc_m[0], n);
    end
    req_d[0] = 1'b0;
    @(negedge clk_vga);
    rst_n = 1'b1;
    ev = 0;
    repeat (5) begin
      @(negedge clk_vga);
      if (busy_m[0]) ev++;
    end
    checks++;
    if (ev !== 0) begin errors++; $display("FAIL busy_after_reset: busy seen %0d cycles, expected 0", ev); end
    serve(0, 24'h004000, 2'd3, ga, fa, la, nw, ng, vp);
    checks++;
    if (nw !== 256 || bc_m[0] !== 16'd1) begin
      errors++; $display("FAIL post_reset_serve: words=%0d bc=%0d, expected 256 1", nw, bc_m[0]);
    end
  endtask

  initial begin
    enable      = 1'b1;
    pattern_sel = 2'd3;
    solid_color = 16'h0000;
    req_d       = '0;
    for (int k = 0; k < 3; k++) addr_d[k] = '0;
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stale();
    test_bars();
    test_stall();
    test_abort();
    test_enable();
    test_patterns();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
